cnn_stage_sequencer: RTL and testbench

//  Generic run-control sequencer for a chain of CNN pipeline stages (conv, tanh, avg-pool, ...).

---
 rtl/cnn_stage_sequencer_if.sv | 26 ++
 rtl/cnn_stage_sequencer.sv | 107 ++++++++++
 tb/tb_cnn_stage_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stage_sequencer_if.sv
// cnn_stage_sequencer_if: controller and stage-side signals of the CNN stage sequencer
interface cnn_stage_sequencer_if #(
  parameter int N_STAGES = 8,
  parameter int CNT_W = 20,
  parameter int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
);
  logic start;
  logic abort;
  logic [N_STAGES-1:0] stage_done;
  logic [N_STAGES-1:0] stage_rst;
  logic [N_STAGES-1:0] stage_active;
  logic [IDX_W-1:0] cur_stage;
  logic [CNT_W-1:0] stage_cnt;
  logic busy;
  logic done;
  logic error;
  logic [IDX_W-1:0] err_stage;
  modport master (
    output start, abort, stage_done,
    input stage_rst, stage_active, cur_stage, stage_cnt, busy, done, error, err_stage
  );
  modport slave (
    input start, abort, stage_done,
    output stage_rst, stage_active, cur_stage, stage_cnt, busy, done, error, err_stage
  );
endinterface

// File: rtl/cnn_stage_sequencer.sv
// cnn_stage_sequencer: releases CNN stage resets in order, advancing on done handshake or cycle budget
module cnn_stage_sequencer #(
  parameter int N_STAGES = 8,
  parameter int CNT_W = 20,
  parameter logic [N_STAGES*CNT_W-1:0] STAGE_BUDGET = {N_STAGES{20'd16}},
  parameter logic [N_STAGES-1:0] USE_DONE = {N_STAGES{1'b1}},
  parameter bit TIMEOUT_EN = 1'b1,
  parameter int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input logic clk,
  input logic reset,
  cnn_stage_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  localparam logic [N_STAGES-1:0] ALL = {N_STAGES{1'b1}};
  localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);
  state_t st, st_n;
  logic [N_STAGES-1:0] rst_q, rst_d, act_q, act_d;
  logic [IDX_W-1:0] cur_q, cur_d, es_q, es_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, bud, lim;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic last, hit, dn, ud, cpl, tmo;
  // a zero budget behaves as a one-cycle budget
  always_comb begin
    bud = STAGE_BUDGET[int'(cur_q)*CNT_W +: CNT_W];
    lim = (bud == '0) ? '0 : bud - 1'b1;
    last = cur_q == IDX_W'(N_STAGES - 1);
    hit = cnt_q == lim;
    dn = bus.stage_done[cur_q];
    ud = USE_DONE[cur_q];
    cpl = ud ? dn : hit;
    tmo = ud && TIMEOUT_EN && hit && !dn;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      rst_q <= ALL;
      act_q <= '0;
      cur_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      es_q <= '0;
    end else begin
      st <= st_n;
      rst_q <= rst_d;
      act_q <= act_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      es_q <= es_d;
    end
  always_comb
    st_n = (st == IDLE) ? (bus.start ? ARM : IDLE)
         : (st == ARM) ? (bus.abort ? IDLE : RUN)
         : (st == RUN && !(bus.abort || tmo || (cpl && last))) ? RUN : IDLE;
  // abort outranks completion; a coincident stage_done outranks timeout because tmo requires !dn
  always_comb begin
    rst_d = rst_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    es_d = es_q;
    err_d = err_q;
    done_d = 1'b0;
    if (st == IDLE) begin
      if (bus.start) begin
        rst_d = ALL;
        err_d = 1'b0;
        cur_d = '0;
        cnt_d = '0;
      end
    end else if (bus.abort) begin
      rst_d = ALL;
      cnt_d = '0;
    end else if (st == ARM) begin
      rst_d = ALL << 1;
      cur_d = '0;
      cnt_d = '0;
    end else if (cpl && !last) begin
      cur_d = cur_q + 1'b1;
      rst_d = rst_q & ~(ONE << cur_d);
      cnt_d = '0;
    end else if (cpl) begin
      done_d = 1'b1;
      cnt_d = '0;
    end else if (tmo) begin
      err_d = 1'b1;
      es_d = cur_q;
      rst_d = ALL;
      cnt_d = '0;
    end else
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    busy_d = st_n != IDLE;
    act_d = (st_n == RUN) ? ONE << cur_d : '0;
  end
  assign bus.stage_rst = rst_q;
  assign bus.stage_active = act_q;
  assign bus.cur_stage = cur_q;
  assign bus.stage_cnt = cnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.error = err_q;
  assign bus.err_stage = es_q;
endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// tb_cnn_stage_sequencer: randomized runs checked against an event-timeline model through a scoreboard
module tb_cnn_stage_sequencer;
  localparam logic [3:0] F = 4'hF;
  typedef struct {int kind; int stg; int at; logic [3:0] rst;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit prev_err_m = 1'b0;
  ev_t q[$];
  cnn_stage_sequencer_if #(.N_STAGES(4), .CNT_W(20), .IDX_W(2)) bus();
  cnn_stage_sequencer #(
    .N_STAGES(4), .CNT_W(20),
    .STAGE_BUDGET({20'd2, 20'd0, 20'd8, 20'd4}),
    .USE_DONE(4'b0010), .TIMEOUT_EN(1'b1), .IDX_W(2)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic push(input int k, input int s, input int t, input logic [3:0] r);
    ev_t e;
    e.kind = k;
    e.stg = s;
    e.at = t;
    e.rst = r;
    q.push_back(e);
  endtask
  // kinds: 0 release, 1 done, 2 timeout, 3 abort end, 4 start accepted, 5 error cleared
  task automatic run(input int d, input int a_r, input int sp_r);
    int s, e_end, a, fin, sp;
    int dur[4];
    int rel[4];
    bit tmo, ab;
    logic [3:0] sd;
    s = cyc + 1;
    tmo = d >= 8;
    dur = '{4, tmo ? 8 : d + 1, 1, 2};
    rel[0] = s + 1;
    for (int k = 1; k < 4; k++) rel[k] = rel[k-1] + dur[k-1];
    e_end = tmo ? rel[1] + 8 : rel[3] + dur[3];
    a = (a_r < 0) ? -1 : s + 1 + a_r % (e_end - s + 3);
    ab = a >= 0 && a <= e_end;
    fin = ab ? a : e_end;
    push(4, 0, s, F);
    if (prev_err_m) push(5, 0, s, F);
    for (int k = 0; k < 4; k++) if (rel[k] < fin) push(0, k, rel[k], F << (k + 1));
    if (ab) push(3, 0, a, F);
    else if (tmo) push(2, 1, e_end, F);
    else push(1, 0, e_end, 4'h0);
    prev_err_m = !ab && tmo;
    sp = s + 1 + sp_r % (fin - s);
    for (int e = s; e <= fin + 4; e++) begin
      sd = 4'($urandom);
      if (e > rel[1] && e <= rel[1] + 8) sd[1] = (e == rel[1] + d + 1);
      if (e == a) sd = F;
      bus.start = (e == s) || (e == sp);
      bus.abort = (e == a);
      bus.stage_done = sd;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask
  task automatic chk_reset_vals(input string p);
    chk({p, "_stage_rst"}, bus.stage_rst, F);
    chk({p, "_stage_active"}, bus.stage_active, 0);
    chk({p, "_cur_stage"}, bus.cur_stage, 0);
    chk({p, "_stage_cnt"}, bus.stage_cnt, 0);
    chk({p, "_busy"}, bus.busy, 0);
    chk({p, "_done"}, bus.done, 0);
    chk({p, "_error"}, bus.error, 0);
    chk({p, "_err_stage"}, bus.err_stage, 0);
  endtask
  initial begin
    logic [3:0] p_rst;
    logic p_busy, p_err;
    int last_rel, zc;
    ev_t obs[$];
    ev_t x, o;
    p_rst = F;
    p_busy = 1'b0;
    p_err = 1'b0;
    last_rel = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        obs.delete();
        o.stg = 0;
        o.at = cyc;
        o.rst = bus.stage_rst;
        if (bus.busy && !p_busy) begin o.kind = 4; obs.push_back(o); end
        if (p_err && !bus.error) begin o.kind = 5; obs.push_back(o); end
        for (int i = 0; i < 4; i++)
          if (p_rst[i] && !bus.stage_rst[i]) begin
            o.kind = 0;
            o.stg = i;
            obs.push_back(o);
            o.stg = 0;
            last_rel = cyc;
          end
        if (bus.done) begin o.kind = 1; obs.push_back(o); end
        if (bus.error && !p_err) begin o.kind = 2; o.stg = int'(bus.err_stage); obs.push_back(o); o.stg = 0; end
        if (p_busy && !bus.busy && !bus.done && !(bus.error && !p_err)) begin o.kind = 3; obs.push_back(o); end
        foreach (obs[j]) begin
          n_chk++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind=%0d stage=%0d edge=%0d rst=%b, expected no event", obs[j].kind, obs[j].stg, obs[j].at, obs[j].rst);
          end else begin
            x = q.pop_front();
            if (x.kind != obs[j].kind || x.stg != obs[j].stg || x.at != obs[j].at || x.rst !== obs[j].rst) begin
              n_fail++;
              $display("FAIL event: got kind=%0d stage=%0d edge=%0d rst=%b, expected kind=%0d stage=%0d edge=%0d rst=%b",
                       obs[j].kind, obs[j].stg, obs[j].at, obs[j].rst, x.kind, x.stg, x.at, x.rst);
            end
          end
        end
        if (bus.stage_rst != p_rst) chk("rst_change_explained", obs.size() != 0, 1);
        zc = $countones(~bus.stage_rst);
        if (bus.busy && zc > 0) begin
          chk("run_cur_stage", bus.cur_stage, zc - 1);
          chk("run_stage_active", bus.stage_active, 1 << (zc - 1));
          chk("run_stage_cnt", bus.stage_cnt, cyc - last_rel);
        end else
          chk("stage_active_off", bus.stage_active, 0);
      end
      p_rst = bus.stage_rst;
      p_busy = bus.busy;
      p_err = bus.error;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stage_done = '0;
    #1 reset = 1'b1;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.stage_done = 4'($urandom);
      @(posedge clk);
      #1;
      chk("idle_stage_rst", bus.stage_rst, F);
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_error", bus.error, 0);
    end
    bus.stage_done = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    run(2, -1, 3);
    run(7, -1, 11);
    run(8, -1, 0);
    run(2, 8, 5);
    run(3, 0, 0);
    run(2, 10, 7);
    run(0, -1, 2);
    run(10, -1, 9);
    run(1, 10, 4);
    for (int i = 0; i < 30; i++)
      run($urandom_range(0, 10), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1, $urandom_range(0, 1000));
    run(9, -1, 1);
    mon_en = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_vals("areset");
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    prev_err_m = 1'b0;
    mon_en = 1'b1;
    run(2, -1, 6);
    run(5, -1, 2);
    repeat (3) @(posedge clk);
    #1 chk("events_drained", q.size(), 0);
    while (q.size() != 0) begin
      ev_t x;
      x = q.pop_front();
      $display("FAIL missing_event: got nothing, expected kind=%0d stage=%0d edge=%0d rst=%b", x.kind, x.stg, x.at, x.rst);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
